// File: rtl/alu_seq_pkg.sv
// Shared op encodings, sequencer state type and default mod settle window.
// The op codes double as the ALU result-mux select.
package alu_seq_pkg;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOR = 3'd3;
    localparam logic [2:0] OP_LT  = 3'd4;
    localparam logic [2:0] OP_ADD = 3'd5;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_MOD = 3'd7;

    localparam int MOD_WAIT_DEFAULT = 34;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_CLR    = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } seq_state_t;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that saturates at zero; zero_o flags the terminal count.
// Load has priority over decrement.
module wait_counter #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Issues one op at a time to the ALU from registered sel/a/b, waits one cycle (or the
// mod window after a clear pulse), then holds the captured result until the response handshake.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MOD_WAIT = MOD_WAIT_DEFAULT,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [2:0]       req_op_i,
    input  logic [WIDTH-1:0] req_a_i,
    input  logic [WIDTH-1:0] req_b_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_result_o,
    output logic             rsp_zero_o,
    output logic             rsp_err_o,
    output logic [2:0]       alu_sel_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic             alu_clr_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_zero_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] op_count_o
);

    localparam int CW = $clog2(MOD_WAIT) + 1;

    seq_state_t       state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             clr_q, clr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, err_q, err_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             cnt_zero;

    // Loaded in CLR so the counter hits zero on the last of MOD_WAIT WAIT cycles.
    wait_counter #(.W(CW)) u_wait (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (state_q == S_CLR),
        .load_val_i (CW'(MOD_WAIT - 1)),
        .dec_i      (state_q == S_WAIT),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        a_d      = a_q;
        b_d      = b_q;
        clr_d    = 1'b0;
        result_d = result_q;
        zero_d   = zero_q;
        err_d    = err_q;
        count_d  = count_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    sel_d = req_op_i;
                    a_d   = req_a_i;
                    b_d   = req_b_i;
                    if (req_op_i == OP_MOD && req_b_i == '0) begin
                        result_d = req_a_i;
                        zero_d   = (req_a_i == '0);
                        err_d    = 1'b1;
                        state_d  = S_RESP;
                    end else if (req_op_i == OP_MOD) begin
                        clr_d   = 1'b1;
                        state_d = S_CLR;
                    end else begin
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                result_d = alu_result_i;
                zero_d   = alu_zero_i;
                err_d    = 1'b0;
                state_d  = S_RESP;
            end
            S_CLR: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_zero) begin
                    result_d = alu_result_i;
                    zero_d   = alu_zero_i;
                    err_d    = 1'b0;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    count_d = count_q + 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            sel_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            clr_q    <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            a_q      <= a_d;
            b_q      <= b_d;
            clr_q    <= clr_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign rsp_valid_o  = (state_q == S_RESP);
    assign busy_o       = (state_q != S_IDLE);
    assign rsp_result_o = result_q;
    assign rsp_zero_o   = zero_q;
    assign rsp_err_o    = err_q;
    assign alu_sel_o    = sel_q;
    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign alu_clr_o    = clr_q;
    assign op_count_o   = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ALU whose mod result only
// becomes valid MOD_WAIT cycles after the clear pulse.
module tb_alu_sequencer;

    localparam int W  = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_op = 3'd0;
    logic [W-1:0]  req_a = '0;
    logic [W-1:0]  req_b = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_result;
    logic          rsp_zero;
    logic          rsp_err;
    logic [2:0]    alu_sel;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic          alu_clr;
    logic [W-1:0]  alu_result;
    logic          alu_zero;
    logic          busy;
    logic [15:0]   op_count;

    int n_asrt = 0;
    int n_fail = 0;
    int mod_age = 1000;
    int clr_pulses = 0;
    int clr_base;

    alu_sequencer #(.WIDTH(W), .MOD_WAIT(MW), .CNT_W(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_op_i     (req_op),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_result_o (rsp_result),
        .rsp_zero_o   (rsp_zero),
        .rsp_err_o    (rsp_err),
        .alu_sel_o    (alu_sel),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_clr_o    (alu_clr),
        .alu_result_i (alu_result),
        .alu_zero_i   (alu_zero),
        .busy_o       (busy),
        .op_count_o   (op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (alu_clr) begin
            mod_age <= 0;
            clr_pulses <= clr_pulses + 1;
        end else if (mod_age < 1000) begin
            mod_age <= mod_age + 1;
        end
    end

    always_comb begin
        alu_result = '0;
        case (alu_sel)
            3'd0: alu_result = alu_a & alu_b;
            3'd1: alu_result = alu_a | alu_b;
            3'd2: alu_result = alu_a ^ alu_b;
            3'd3: alu_result = ~(alu_a | alu_b);
            3'd4: alu_result = {31'd0, alu_a < alu_b};
            3'd5: alu_result = alu_a + alu_b;
            3'd6: alu_result = alu_a - alu_b;
            default: alu_result = (mod_age >= MW - 1 && alu_b != 0) ? alu_a % alu_b : 32'hBAD0BAD0;
        endcase
        alu_zero = (alu_result == '0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        step();
        req_valid = 1'b0;
    endtask

    task automatic handshake(input int exp_cnt);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("hs_req_ready", {31'd0, req_ready}, 32'd1);
        chk("hs_op_count", {16'd0, op_count}, exp_cnt);
    endtask

    initial begin
        #2;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_clr", {31'd0, alu_clr}, 32'd0);
        chk("rst_op_count", {16'd0, op_count}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // ADD 5+7: response one edge after accept
        issue(3'd5, 32'd5, 32'd7);
        chk("add_e0_busy", {31'd0, busy}, 32'd1);
        chk("add_e0_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("add_e0_alu_sel", {29'd0, alu_sel}, 32'd5);
        step();
        chk("add_e1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("add_result", rsp_result, 32'd12);
        chk("add_zero", {31'd0, rsp_zero}, 32'd0);
        chk("add_err", {31'd0, rsp_err}, 32'd0);
        handshake(1);

        issue(3'd6, 32'd9, 32'd9);
        step();
        chk("sub_result", rsp_result, 32'd0);
        chk("sub_zero", {31'd0, rsp_zero}, 32'd1);
        handshake(2);

        issue(3'd4, 32'd3, 32'd4);
        step();
        chk("lt_result", rsp_result, 32'd1);
        chk("lt_zero", {31'd0, rsp_zero}, 32'd0);
        handshake(3);

        // Modulo 17%5 through the full wait window
        clr_base = clr_pulses;
        issue(3'd7, 32'd17, 32'd5);
        chk("mod_e0_clr", {31'd0, alu_clr}, 32'd1);
        step();
        chk("mod_e1_clr", {31'd0, alu_clr}, 32'd0);
        chk("mod_e1_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        for (int k = 1; k < MW; k++) begin
            step();
            chk("mod_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        step();
        chk("mod_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mod_result", rsp_result, 32'd2);
        chk("mod_err", {31'd0, rsp_err}, 32'd0);
        chk("mod_clr_pulses", clr_pulses - clr_base, 32'd1);
        handshake(4);

        // Modulo by zero: immediate error response, no clear
        clr_base = clr_pulses;
        issue(3'd7, 32'd13, 32'd0);
        chk("mod0_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("mod0_result", rsp_result, 32'd13);
        chk("mod0_err", {31'd0, rsp_err}, 32'd1);
        chk("mod0_zero", {31'd0, rsp_zero}, 32'd0);
        chk("mod0_clr", {31'd0, alu_clr}, 32'd0);
        handshake(5);
        chk("mod0_clr_pulses", clr_pulses - clr_base, 32'd0);

        // Backpressure with a pending request held on the input
        issue(3'd5, 32'd2, 32'd3);
        req_valid = 1'b1;
        req_op    = 3'd2;
        req_a     = 32'd6;
        req_b     = 32'd12;
        step();
        chk("bp_result", rsp_result, 32'd5);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_hold_result", rsp_result, 32'd5);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_alu_a", alu_a, 32'd2);
        end
        handshake(6);
        step();
        req_valid = 1'b0;
        chk("bp_accept_busy", {31'd0, busy}, 32'd1);
        chk("bp_accept_sel", {29'd0, alu_sel}, 32'd2);
        chk("bp_accept_a", alu_a, 32'd6);
        step();
        chk("xor_result", rsp_result, 32'd10);
        handshake(7);

        // Reset during the mod wait window
        issue(3'd7, 32'd20, 32'd6);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mrst_alu_sel", {29'd0, alu_sel}, 32'd0);
        chk("mrst_alu_a", alu_a, 32'd0);
        chk("mrst_alu_b", alu_b, 32'd0);
        chk("mrst_result", rsp_result, 32'd0);
        chk("mrst_op_count", {16'd0, op_count}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < MW + 2; k++) begin
            step();
            chk("mrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        issue(3'd5, 32'd1, 32'd1);
        step();
        chk("post_rst_valid", {31'd0, rsp_valid}, 32'd1);
        chk("post_rst_result", rsp_result, 32'd2);
        handshake(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
